game_ctrl: RTL
==============

Name: game_ctrl

Overview:
Referee/sequencer for the pong core. Consumes the ball block's out_left/out_right edge events and start button, and drives the ball block's reset and speed inputs. Keeps both scores, inserts serve and point pauses, ramps rally speed, and declares a winner. Runs on the same 2 kHz game clock as the ball block.

Parameters:
WIN_SCORE, 9, score that ends the game (1..15)
SERVE_DELAY, 2000, cycles ball held at centre before release (1 s @ 2 kHz)
POINT_PAUSE, 1000, cycles of post-point pause before next serve
SPEED_INIT, 4, speed loaded at every serve (1..SPEED_MAX)
SPEED_MAX, 15, speed saturation value (<=15)
RAMP_CYCLES, 4000, PLAY cycles per +1 speed step
FLASH_DIV, 125, cycles per point_flash toggle during POINT

Ports:
clk  input  1  game clock
reset  input  1  synchronous, active-low (0 = reset)
start  input  1  raw start button, asynchronous level
out_left  input  1  ball reached far-left edge
out_right  input  1  ball reached far-right edge
ball_reset  output  1  active-high synchronous reset to ball block
speed  output  5  signed speed to ball block; always positive
score_l  output  4  left player score
score_r  output  4  right player score
point_flash  output  1  blink for display during POINT
game_over  output  1  high in OVER
winner  output  1  0 = left, 1 = right; valid when game_over

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, ball_reset=1, speed=SPEED_INIT, scores=0, point_flash=0, game_over=0, winner=0, all timers/synchronizer flops 0.
- All outputs registered.
- start: 2-flop synchronizer, then rise detect (sync & !sync_q). start_rise is 3 cycles after a clean input edge at earliest.
- States:
  - IDLE: ball_reset=1. start_rise -> SERVE; scores cleared.
  - SERVE: ball_reset=1, speed=SPEED_INIT, timer loaded SERVE_DELAY-1 on entry. Timer==0 -> PLAY. ball_reset drops on the PLAY entry edge, so it is high for exactly SERVE_DELAY cycles.
  - PLAY: ball_reset=0.
    - out_left -> score_r+1. out_right -> score_l+1. Both registered 1 cycle after the sampled event; ball_reset=1 in the same cycle.
    - If the new score == WIN_SCORE -> OVER, with winner=1 (right) or 0 (left); otherwise -> POINT.
    - Simultaneous out_left and out_right: out_left has priority; only score_r increments.
    - Speed ramp: counter counts PLAY cycles. At RAMP_CYCLES-1, speed<=min(speed+1, SPEED_MAX) and the counter clears. The counter clears on every PLAY entry.
  - POINT: ball_reset=1, timer=POINT_PAUSE-1. point_flash toggles every FLASH_DIV cycles, starting at 1 on entry. Timer==0 -> SERVE, point_flash<=0.
  - OVER: ball_reset=1, game_over=1, scores and winner held. start_rise -> SERVE with scores=0, game_over=0.
- out_left/out_right outside PLAY are ignored. A multi-cycle assertion counts once, because PLAY is left on the first cycle.
- start_rise outside IDLE/OVER is ignored.
- Scores never exceed WIN_SCORE and have no wrap.
- Reset mid-operation: immediate return to IDLE values on the next edge, regardless of state or timer.
- Timer width: $clog2(max(SERVE_DELAY, POINT_PAUSE)+1). Ramp counter width: $clog2(RAMP_CYCLES). Flash counter width: $clog2(FLASH_DIV).
- speed[4] is always 0.

Decomposition:
- pong_defs.vh (shared include): state encodings (ST_IDLE=0, ST_SERVE=1, ST_PLAY=2, ST_POINT=3, ST_OVER=4; 3 bits), SCORE_W=4, SPEED_W=5.
- One sub-module, down_timer: load/value/zero flag with parameterised width. Reused for the serve/point delay and for the flash divider.
- The ramp counter stays inline.

Test Plan:
All with SERVE_DELAY=4, POINT_PAUSE=3, WIN_SCORE=3, RAMP_CYCLES=5, FLASH_DIV=1, SPEED_INIT=4, SPEED_MAX=6.
- Reset low 2 cycles, release, idle 10 cycles -> ball_reset=1, speed=4, scores 0/0, state IDLE.
- start pulse -> SERVE entered 3 cycles later; ball_reset high exactly 4 cycles, then 0.
- PLAY 20 cycles, no events -> speed 4->5 at cycle 5, 5->6 at cycle 10, stays 6.
- In PLAY, 1-cycle out_left -> next cycle score_r=1, ball_reset=1, POINT. point_flash toggles 1,0,1 for 3 cycles, then SERVE, then speed=4 again.
- out_left and out_right in the same cycle -> score_r+1 only, score_l unchanged.
- Drive out_right until score_l=3 -> OVER, game_over=1, winner=0. out_* ignored there. start -> scores 0/0, SERVE. Assert reset mid-SERVE -> IDLE values the next cycle.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the pong referee: state encoding, output widths
// and a width helper for parameterised counters.
package game_ctrl_pkg;

    localparam int SCORE_W = 4;
    localparam int SPEED_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Counter width for values 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_ctrl_down_timer.sv
// Loadable down counter that parks at zero; zero flag is decoded from the
// count register. Used for the serve/point delay and the flash divider.
module down_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load takes precedence; otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/game_ctrl.sv
// Pong referee: synchronises the start button, sequences serve / play /
// point / game-over, keeps both scores, ramps rally speed and drives the
// ball block's reset and speed inputs. All outputs are registered.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 2000,
    parameter int POINT_PAUSE = 1000,
    parameter int SPEED_INIT  = 4,
    parameter int SPEED_MAX   = 15,
    parameter int RAMP_CYCLES = 4000,
    parameter int FLASH_DIV   = 125
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      out_left,
    input  logic                      out_right,
    output logic                      ball_reset,
    output logic signed [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0]        score_l,
    output logic [SCORE_W-1:0]        score_r,
    output logic                      point_flash,
    output logic                      game_over,
    output logic                      winner
);

    localparam int TMR_W   = cnt_w(max_int(SERVE_DELAY, POINT_PAUSE) + 1);
    localparam int RAMP_W  = cnt_w(RAMP_CYCLES);
    localparam int FLASH_W = cnt_w(FLASH_DIV);

    localparam logic signed [SPEED_W-1:0] SPD_INIT = SPEED_W'(SPEED_INIT);
    localparam logic signed [SPEED_W-1:0] SPD_MAX  = SPEED_W'(SPEED_MAX);
    localparam logic [SCORE_W-1:0]        WIN      = SCORE_W'(WIN_SCORE);

    // Speed step that saturates at the configured ceiling
    function automatic logic signed [SPEED_W-1:0] sat_speed_inc(
        input logic signed [SPEED_W-1:0] s);
        return (s >= SPD_MAX) ? SPD_MAX : s + SPEED_W'(1);
    endfunction

    state_t                      state, state_d;
    logic                        start_s1, start_s2, start_q, start_rise;
    logic [RAMP_W-1:0]           ramp_cnt, ramp_d;
    logic                        tmr_load, tmr_zero;
    logic [TMR_W-1:0]            tmr_val;
    logic                        flash_load, flash_zero;
    logic                        ball_reset_d, flash_d, game_over_d, winner_d;
    logic signed [SPEED_W-1:0]   speed_d;
    logic [SCORE_W-1:0]          score_l_d, score_r_d;

    down_timer #(.W(TMR_W)) u_delay (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    down_timer #(.W(FLASH_W)) u_flash (
        .clk   (clk),
        .reset (reset),
        .load  (flash_load),
        .value (FLASH_W'(FLASH_DIV - 1)),
        .zero  (flash_zero)
    );

    assign start_rise = start_s2 & ~start_q;

    // Start synchroniser, state register and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_s1    <= 1'b0;
            start_s2    <= 1'b0;
            start_q     <= 1'b0;
            state       <= ST_IDLE;
            ramp_cnt    <= '0;
            ball_reset  <= 1'b1;
            speed       <= SPD_INIT;
            score_l     <= '0;
            score_r     <= '0;
            point_flash <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            start_s1    <= start;
            start_s2    <= start_s1;
            start_q     <= start_s2;
            state       <= state_d;
            ramp_cnt    <= ramp_d;
            ball_reset  <= ball_reset_d;
            speed       <= speed_d;
            score_l     <= score_l_d;
            score_r     <= score_r_d;
            point_flash <= flash_d;
            game_over   <= game_over_d;
            winner      <= winner_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d      = state;
        ramp_d       = ramp_cnt;
        ball_reset_d = ball_reset;
        speed_d      = speed;
        score_l_d    = score_l;
        score_r_d    = score_r;
        flash_d      = point_flash;
        game_over_d  = game_over;
        winner_d     = winner;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        flash_load   = 1'b0;

        case (state)
            ST_IDLE: begin
                ball_reset_d = 1'b1;
                if (start_rise) begin
                    state_d   = ST_SERVE;
                    score_l_d = '0;
                    score_r_d = '0;
                    speed_d   = SPD_INIT;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(SERVE_DELAY - 1);
                end
            end
            ST_SERVE: begin
                ball_reset_d = 1'b1;
                speed_d      = SPD_INIT;
                if (tmr_zero) begin
                    state_d      = ST_PLAY;
                    ball_reset_d = 1'b0;
                    ramp_d       = '0;
                end
            end
            ST_PLAY: begin
                ball_reset_d = 1'b0;
                // Left miss has priority when both edges arrive together
                if (out_left || out_right) begin
                    ball_reset_d = 1'b1;
                    if (out_left)
                        score_r_d = score_r + SCORE_W'(1);
                    else
                        score_l_d = score_l + SCORE_W'(1);
                    if ((out_left && score_r_d == WIN) || (!out_left && score_l_d == WIN)) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                        winner_d    = out_left;
                    end else begin
                        state_d    = ST_POINT;
                        tmr_load   = 1'b1;
                        tmr_val    = TMR_W'(POINT_PAUSE - 1);
                        flash_load = 1'b1;
                        flash_d    = 1'b1;
                    end
                end else if (ramp_cnt == RAMP_W'(RAMP_CYCLES - 1)) begin
                    speed_d = sat_speed_inc(speed);
                    ramp_d  = '0;
                end else begin
                    ramp_d = ramp_cnt + RAMP_W'(1);
                end
            end
            ST_POINT: begin
                ball_reset_d = 1'b1;
                if (tmr_zero) begin
                    state_d  = ST_SERVE;
                    flash_d  = 1'b0;
                    speed_d  = SPD_INIT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SERVE_DELAY - 1);
                end else if (flash_zero) begin
                    flash_d    = ~point_flash;
                    flash_load = 1'b1;
                end
            end
            ST_OVER: begin
                ball_reset_d = 1'b1;
                game_over_d  = 1'b1;
                if (start_rise) begin
                    state_d     = ST_SERVE;
                    score_l_d   = '0;
                    score_r_d   = '0;
                    game_over_d = 1'b0;
                    speed_d     = SPD_INIT;
                    tmr_load    = 1'b1;
                    tmr_val     = TMR_W'(SERVE_DELAY - 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
